// File: rtl/iagu_fc_if.sv
// rtl/iagu_fc_if.sv - scheduler, feature buffer and NPE feature register file signals of the FC input address generator
interface iagu_fc_if;
    logic        start_calculate;
    logic [3:0]  mode;
    logic [12:0] addr_start_f;
    logic [7:0]  in_piece;
    logic [7:0]  out_piece;
    logic        i_group_end;
    logic [12:0] o_f_addr;
    logic        o_rd_en;
    logic        o_f_we;
    logic [4:0]  o_f_idx;
    logic        o_feature_load_end;
    logic        o_busy;
    logic        o_done;

    modport master (
        output start_calculate, mode, addr_start_f, in_piece, out_piece, i_group_end,
        input  o_f_addr, o_rd_en, o_f_we, o_f_idx, o_feature_load_end, o_busy, o_done
    );

    modport slave (
        input  start_calculate, mode, addr_start_f, in_piece, out_piece, i_group_end,
        output o_f_addr, o_rd_en, o_f_we, o_f_idx, o_feature_load_end, o_busy, o_done
    );
endinterface

// File: rtl/iagu_fc.sv
// rtl/iagu_fc.sv - FC-mode feature address generator: streams one piece of GROUP_NUM words per weight group
module iagu_fc #(
    parameter int          GROUP_NUM = 32,
    parameter logic [3:0]  FC_MODE   = 4'd2
) (
    input  logic       clk,
    input  logic       rst,
    iagu_fc_if.slave   bus
);
    // Word counter and write index are 5 bits wide, so GROUP_NUM is at most 32.
    localparam logic [4:0]  K_LAST       = 5'(GROUP_NUM - 1);
    localparam logic [12:0] GROUP_STRIDE = 13'(GROUP_NUM);

    typedef enum logic [2:0] {IDLE, LOAD, LAST, READY, NEXT} state_t;

    state_t      state_q, state_d;
    logic [12:0] base_q, base_d;
    logic [7:0]  in_q, in_d;
    logic [7:0]  out_q, out_d;
    logic [7:0]  ip_q, ip_d;
    logic [7:0]  op_q, op_d;
    logic [4:0]  k_q, k_d;
    logic        we_q;
    logic [4:0]  idx_q;

    logic        rd_en;
    logic        ip_last;
    logic        op_last;
    logic [12:0] addr;

    assign rd_en   = (state_q == LOAD);
    assign ip_last = (ip_q == in_q - 8'd1);
    assign op_last = (op_q == out_q - 8'd1);
    // Address depends only on the input piece, so every output piece re-reads the same features.
    assign addr    = base_q + 13'(ip_q) * GROUP_STRIDE + 13'(k_q);

    // Next-state and tiling counters; a start pulse in any state overrides the normal flow.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        in_d    = in_q;
        out_d   = out_q;
        ip_d    = ip_q;
        op_d    = op_q;
        k_d     = k_q;
        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            LOAD: begin
                if (k_q == K_LAST) begin
                    state_d = LAST;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            LAST: begin
                state_d = READY;
            end
            READY: begin
                if (bus.i_group_end) begin
                    state_d = NEXT;
                end
            end
            NEXT: begin
                k_d = '0;
                if (ip_last) begin
                    ip_d = '0;
                    if (op_last) begin
                        op_d    = '0;
                        state_d = IDLE;
                    end else begin
                        op_d    = op_q + 8'd1;
                        state_d = LOAD;
                    end
                end else begin
                    ip_d    = ip_q + 8'd1;
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (bus.start_calculate) begin
            ip_d = '0;
            op_d = '0;
            k_d  = '0;
            if (bus.mode == FC_MODE) begin
                base_d  = bus.addr_start_f;
                in_d    = (bus.in_piece == 8'd0) ? 8'd1 : bus.in_piece;
                out_d   = (bus.out_piece == 8'd0) ? 8'd1 : bus.out_piece;
                state_d = LOAD;
            end else begin
                state_d = IDLE;
            end
        end
    end

    // State, latched job parameters and the one-cycle-delayed register file write port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            base_q  <= '0;
            in_q    <= '0;
            out_q   <= '0;
            ip_q    <= '0;
            op_q    <= '0;
            k_q     <= '0;
            we_q    <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            in_q    <= in_d;
            out_q   <= out_d;
            ip_q    <= ip_d;
            op_q    <= op_d;
            k_q     <= k_d;
            // A restart discards the read that is still in flight.
            we_q    <= rd_en && !bus.start_calculate;
            idx_q   <= k_q;
        end
    end

    assign bus.o_rd_en            = rd_en;
    assign bus.o_f_addr           = rd_en ? addr : 13'd0;
    assign bus.o_f_we             = we_q;
    assign bus.o_f_idx            = idx_q;
    assign bus.o_feature_load_end = (state_q == READY);
    assign bus.o_busy             = (state_q != IDLE);
    assign bus.o_done             = (state_q == NEXT) && ip_last && op_last;
endmodule
